// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state encoding, key code width and row/column-to-code map for the keypad scanner.
package keypad_pkg;

    localparam int CODE_W = 4;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, RELEASE} state_t;

    // Indexed by {row, col}: r0 1 2 3 A, r1 4 5 6 B, r2 7 8 9 C, r3 E 0 F D
    localparam logic [CODE_W-1:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic [1:0] low_index(input logic [3:0] rows);
        return !rows[0] ? 2'd0 : !rows[1] ? 2'd1 : !rows[2] ? 2'd2 : 2'd3;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous level inputs, resetting to all ones.
module sync_2ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with ghost rejection, press/release debounce and key strobe.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int REPEAT_TICKS   = 500
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [3:0]        i_row,
    output logic [3:0]        o_col,
    output logic [CODE_W-1:0] o_digit,
    output logic              o_valid,
    output logic              o_key_down
);

    localparam int DIV_W = $clog2(SCAN_DIV + 1);
    localparam int DEB_W = $clog2(DEBOUNCE_TICKS + 1);

    if (SCAN_DIV < 1 || DEBOUNCE_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_params
        $error("keypad_scanner: SCAN_DIV, DEBOUNCE_TICKS and REPEAT_TICKS must be positive");
    end

    logic [3:0]        row_s;
    logic [DIV_W-1:0]  tick_cnt;
    logic              tick;
    state_t            state, state_n;
    logic [1:0]        col_idx, col_n;
    logic [1:0]        row_idx, row_n;
    logic [DEB_W-1:0]  deb_cnt, deb_n, deb_inc;
    logic [CODE_W-1:0] digit_n;
    logic              kd_n;
    logic              one_low;
    logic [1:0]        low_row;
    logic              rpt_valid;

    sync_2ff #(.W(4)) u_sync (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .d     (i_row),
        .q     (row_s)
    );

    assign tick    = tick_cnt == DIV_W'(SCAN_DIV - 1);
    assign one_low = $onehot(~row_s);
    assign low_row = low_index(row_s);
    assign deb_inc = deb_cnt + 1'b1;
    assign o_col   = ~(4'b0001 << col_idx);
    assign o_valid = (state == EMIT) | rpt_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            tick_cnt <= '0;
        else
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= SCAN;
            col_idx    <= 2'd0;
            row_idx    <= 2'd0;
            deb_cnt    <= '0;
            o_digit    <= '0;
            o_key_down <= 1'b0;
        end else begin
            state      <= state_n;
            col_idx    <= col_n;
            row_idx    <= row_n;
            deb_cnt    <= deb_n;
            o_digit    <= digit_n;
            o_key_down <= kd_n;
        end
    end

    always_comb begin
        state_n = state;
        col_n   = col_idx;
        row_n   = row_idx;
        deb_n   = deb_cnt;
        digit_n = o_digit;
        kd_n    = o_key_down;
        case (state)
            SCAN: begin
                if (tick && one_low) begin
                    row_n   = low_row;
                    deb_n   = DEB_W'(1);
                    state_n = DEBOUNCE;
                end else if (tick) begin
                    col_n = col_idx + 2'd1;
                end
            end
            DEBOUNCE: begin
                if (tick && one_low && low_row == row_idx) begin
                    deb_n = deb_inc;
                    if (deb_inc >= DEB_W'(DEBOUNCE_TICKS)) begin
                        deb_n   = '0;
                        state_n = EMIT;
                        digit_n = KEY_MAP[{row_idx, col_idx}];
                        kd_n    = 1'b1;
                    end
                end else if (tick) begin
                    deb_n   = '0;
                    state_n = SCAN;
                    col_n   = col_idx + 2'd1;
                end
            end
            EMIT: begin
                deb_n   = '0;
                state_n = RELEASE;
            end
            RELEASE: begin
                // Column stays parked on the latched key; any low row restarts the release count
                if (tick && &row_s) begin
                    deb_n = deb_inc;
                    if (deb_inc >= DEB_W'(DEBOUNCE_TICKS)) begin
                        deb_n   = '0;
                        kd_n    = 1'b0;
                        state_n = SCAN;
                        col_n   = col_idx + 2'd1;
                    end
                end else if (tick) begin
                    deb_n = '0;
                end
            end
            default: state_n = SCAN;
        endcase
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_TICKS + 1);

    logic [RPT_W-1:0] rpt_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rpt_cnt   <= '0;
            rpt_valid <= 1'b0;
        end else begin
            rpt_valid <= 1'b0;
            if (state != RELEASE) begin
                rpt_cnt <= '0;
            end else if (tick && !row_s[row_idx]) begin
                if (rpt_cnt == RPT_W'(REPEAT_TICKS - 1)) begin
                    rpt_cnt   <= '0;
                    rpt_valid <= 1'b1;
                end else begin
                    rpt_cnt <= rpt_cnt + 1'b1;
                end
            end else if (tick) begin
                rpt_cnt <= '0;
            end
        end
    end
`else
    assign rpt_valid = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized and directed checks of the keypad scanner against a keypad/press-level model.
module tb_keypad_scanner;

    localparam int SD = 5;
    localparam int DT = 20;
    localparam int RT = 500;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pressed = '0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  digit;
    logic        valid;
    logic        key_down;

    int tests = 0;
    int fails = 0;
    int adj_viol = 0;
    int col_viol = 0;
    logic prev_valid = 1'b0;
    logic [3:0] strobes[$];

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DT), .REPEAT_TICKS(RT)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_row      (row),
        .o_col      (col),
        .o_digit    (digit),
        .o_valid    (valid),
        .o_key_down (key_down)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to its column when that column is driven low
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (rst_n && valid) strobes.push_back(digit);
        if (valid && prev_valid) adj_viol++;
        if (!$onehot(~col)) col_viol++;
        prev_valid = valid;
    end

    function automatic logic [3:0] code_of(input int idx);
        string layout = "123A456B789CE0FD";
        byte ch = layout[idx];
        return (ch <= 8'h39) ? 4'(ch - 8'h30) : 4'(ch - 8'h41 + 10);
    endfunction

    task automatic ticks(input int n);
        repeat (n * SD) @(posedge clk);
    endtask

    task automatic hold(input int idx, input int n);
        pressed[idx] = 1'b1;
        ticks(n);
        pressed = '0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        tests++; if (col !== 4'b1110) begin fails++; $display("FAIL reset_col: got %b expected 1110", col); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", valid); end
        tests++; if (digit !== 4'h0) begin fails++; $display("FAIL reset_digit: got %h expected 0", digit); end
        tests++; if (key_down !== 1'b0) begin fails++; $display("FAIL reset_key_down: got %b expected 0", key_down); end
        rst_n = 1'b1;
        ticks(2);
    endtask

    task automatic test_single_press;
        int n = strobes.size();
        hold(5, 30);
        ticks(18);
        tests++; if (key_down !== 1'b1) begin fails++; $display("FAIL kd_held_after_release: got %b expected 1", key_down); end
        ticks(4);
        tests++; if (key_down !== 1'b0) begin fails++; $display("FAIL kd_fall_after_release: got %b expected 0", key_down); end
        tests++; if (strobes.size() != n + 1) begin fails++; $display("FAIL single_count: got %0d expected %0d", strobes.size() - n, 1); end
        else begin
            tests++; if (strobes[n] !== 4'h5) begin fails++; $display("FAIL single_digit: got %h expected 5", strobes[n]); end
        end
        ticks(10);
    endtask

    task automatic test_short_press;
        int n = strobes.size();
        logic [3:0] c0;
        hold(2, 10);
        ticks(30);
        tests++; if (strobes.size() != n) begin fails++; $display("FAIL short_no_strobe: got %0d expected 0", strobes.size() - n); end
        tests++; if (key_down !== 1'b0) begin fails++; $display("FAIL short_key_down: got %b expected 0", key_down); end
        @(negedge clk);
        c0 = col;
        repeat (SD) @(negedge clk);
        tests++; if (col !== {c0[2:0], c0[3]}) begin fails++; $display("FAIL short_rotate: got %b expected %b", col, {c0[2:0], c0[3]}); end
    endtask

    task automatic test_ghost;
        int n = strobes.size();
        int kd_seen = 0;
        pressed[0] = 1'b1;
        pressed[8] = 1'b1;
        repeat (40 * SD) begin
            @(negedge clk);
            if (key_down) kd_seen++;
        end
        pressed = '0;
        ticks(5);
        tests++; if (strobes.size() != n) begin fails++; $display("FAIL ghost_no_strobe: got %0d expected 0", strobes.size() - n); end
        tests++; if (kd_seen != 0) begin fails++; $display("FAIL ghost_key_down: got %0d cycles high expected 0", kd_seen); end
    endtask

    task automatic test_reset_mid;
        int n = strobes.size();
        int k = 0;
        pressed[9] = 1'b1;
        @(negedge clk);
        while (col !== 4'b1101 && k < 10 * SD) begin
            @(negedge clk);
            k++;
        end
        tests++; if (col !== 4'b1101) begin fails++; $display("FAIL reset_mid_col_reach: got %b expected 1101", col); end
        ticks(15);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++; if (col !== 4'b1110) begin fails++; $display("FAIL reset_mid_col: got %b expected 1110", col); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_mid_valid: got %b expected 0", valid); end
        tests++; if (strobes.size() != n) begin fails++; $display("FAIL reset_mid_early: got %0d expected 0", strobes.size() - n); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ticks(19);
        tests++; if (strobes.size() != n) begin fails++; $display("FAIL reset_mid_no_stale: got %0d expected 0", strobes.size() - n); end
        ticks(6);
        pressed = '0;
        tests++; if (strobes.size() != n + 1) begin fails++; $display("FAIL reset_mid_fresh: got %0d expected 1", strobes.size() - n); end
        else begin
            tests++; if (strobes[n] !== 4'h8) begin fails++; $display("FAIL reset_mid_digit: got %h expected 8", strobes[n]); end
        end
        ticks(30);
    endtask

    task automatic test_autorepeat;
        int n = strobes.size();
        int bad = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
        int exp_n = 4;
`else
        int exp_n = 1;
`endif
        hold(13, 1600);
        ticks(30);
        tests++; if (strobes.size() != n + exp_n) begin fails++; $display("FAIL hold_count: got %0d expected %0d", strobes.size() - n, exp_n); end
        for (int i = n; i < strobes.size(); i++) if (strobes[i] !== 4'h0) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL hold_digit: got %0d non-zero codes expected 0", bad); end
    endtask

    task automatic test_back_to_back;
        int n = strobes.size();
        int keys[3] = '{1, 5, 10};
        logic [3:0] exp[3] = '{4'h2, 4'h5, 4'h9};
        foreach (keys[i]) begin
            hold(keys[i], 25);
            ticks(25);
        end
        tests++; if (strobes.size() != n + 3) begin fails++; $display("FAIL seq_count: got %0d expected 3", strobes.size() - n); end
        else begin
            for (int i = 0; i < 3; i++) begin
                tests++; if (strobes[n+i] !== exp[i]) begin fails++; $display("FAIL seq_digit%0d: got %h expected %h", i, strobes[n+i], exp[i]); end
            end
        end
    endtask

    task automatic test_random;
        int n = strobes.size();
        logic [3:0] exp_q[$];
        for (int i = 0; i < 12; i++) begin
            int idx = int'($urandom_range(15, 0));
            bit long_press = $urandom_range(1, 0) == 1;
            int dur = long_press ? int'($urandom_range(60, 25)) : int'($urandom_range(12, 3));
            if (long_press) exp_q.push_back(code_of(idx));
            hold(idx, dur);
            ticks(int'($urandom_range(35, 25)));
        end
        tests++; if (strobes.size() - n != exp_q.size()) begin fails++; $display("FAIL rand_count: got %0d expected %0d", strobes.size() - n, exp_q.size()); end
        else begin
            foreach (exp_q[i]) begin
                tests++; if (strobes[n+i] !== exp_q[i]) begin fails++; $display("FAIL rand_digit%0d: got %h expected %h", i, strobes[n+i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_invariants;
        tests++; if (adj_viol != 0) begin fails++; $display("FAIL valid_adjacent: got %0d expected 0", adj_viol); end
        tests++; if (col_viol != 0) begin fails++; $display("FAIL col_onehot: got %0d expected 0", col_viol); end
    endtask

    initial begin
        test_reset;
        test_single_press;
        test_short_press;
        test_ghost;
        test_reset_mid;
        test_back_to_back;
        test_random;
        test_autorepeat;
        test_invariants;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
